// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, minimum divisor and receiver FSM states.
package uart_pkg;

  localparam int unsigned UART_DATA_W  = 8;
  localparam int unsigned UART_MIN_DIV = 4;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } uart_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [LvlW-1:0]  level_q;
  logic             push_ok, pop_ok;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LvlW'(DEPTH));
  // A pop in the same cycle frees the slot, so a push at full is still taken.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + PtrW'(1);
      if (pop_ok)  rptr_q <= rptr_q + PtrW'(1);
      level_q <= level_q + LvlW'(push_ok) - LvlW'(pop_ok);
    end
  end

  assign rdata = empty ? '0 : mem_q[rptr_q];
  assign level = level_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with mid-bit sampling, FWFT byte buffer and sticky error flags.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx,
  input  logic [DIV_W-1:0]              clk_div,
  output logic [UART_DATA_W-1:0]        rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          rx_busy,
  output logic                          frame_err,
  output logic                          overrun,
  input  logic                          clear_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned BitW = $clog2(UART_DATA_W);

  uart_state_e            state_q, state_d;
  logic                   rx_meta_q, rxs_q, rxs_prev_q;
  logic [DIV_W-1:0]       cnt_q, cnt_d, div_q, div_d, div_sel;
  logic [BitW-1:0]        bit_q, bit_d;
  logic [UART_DATA_W-1:0] shift_q, shift_d;
  logic                   frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic                   fe_set, ov_set, push, fall;
  logic                   fifo_full, fifo_empty;

  // Line idles high, so the synchroniser resets to 1 to avoid a false start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      rx_meta_q  <= rx;
      rxs_q      <= rx_meta_q;
      rxs_prev_q <= rxs_q;
    end
  end

  assign fall    = rxs_prev_q & ~rxs_q;
  assign div_sel = (clk_div < DIV_W'(UART_MIN_DIV)) ? DIV_W'(UART_MIN_DIV) : clk_div;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    push    = 1'b0;
    fe_set  = 1'b0;
    ov_set  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fall) begin
          div_d   = div_sel;
          cnt_d   = (div_sel >> 1) - DIV_W'(1);
          state_d = StStart;
        end
      end
      StStart: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DIV_W'(1);
        end else if (rxs_q) begin
          state_d = StIdle;
        end else begin
          cnt_d   = div_q - DIV_W'(1);
          bit_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DIV_W'(1);
        end else begin
          shift_d = {rxs_q, shift_q[UART_DATA_W-1:1]};
          cnt_d   = div_q - DIV_W'(1);
          if (bit_q == BitW'(UART_DATA_W - 1)) state_d = StStop;
          else                                 bit_d   = bit_q + BitW'(1);
        end
      end
      StStop: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DIV_W'(1);
        end else if (rxs_q) begin
          if (!fifo_full || rx_ready) push   = 1'b1;
          else                        ov_set = 1'b1;
          state_d = StIdle;
        end else begin
          fe_set  = 1'b1;
          state_d = StBreak;
        end
      end
      StBreak: begin
        if (rxs_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A new error in the clearing cycle wins over the clear.
    frame_err_d = (frame_err_q & ~clear_err) | fe_set;
    overrun_d   = (overrun_q & ~clear_err) | ov_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      div_q       <= DIV_W'(UART_MIN_DIV);
      bit_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  sync_fifo #(
    .WIDTH (UART_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (shift_d),
    .pop   (rx_ready),
    .rdata (rx_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign rx_valid  = ~fifo_empty;
  assign rx_busy   = (state_q != StIdle);
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: serial frames in, popped bytes and flags checked.
module tb_uart_rx_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx;
  logic [15:0] clk_div;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        rx_busy;
  logic        frame_err;
  logic        overrun;
  logic        clear_err;
  logic [2:0]  fifo_level;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int start_cyc = 0;
  int rise_cyc = 0;
  int busy_total = 0;
  int busy_base;
  logic valid_prev = 1'b0;

  uart_rx_fifo #(
    .FIFO_DEPTH (4),
    .DIV_W      (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .clk_div    (clk_div),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_busy    (rx_busy),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .clear_err  (clear_err),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe rx_valid rise time and total busy cycles away from the active edge.
  always @(negedge clk) begin
    if (rx_valid && !valid_prev) rise_cyc = cyc;
    valid_prev = rx_valid;
    if (rx_busy) busy_total = busy_total + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_time(input logic v);
    rx = v;
    tick((clk_div < 16'd4) ? 4 : int'(clk_div));
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    start_cyc = cyc;
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(stop);
    rx = 1'b1;
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] exp);
    check({tag, " valid"}, rx_valid, 1);
    check({tag, " data"}, rx_data, exp);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    rx        = 1'b1;
    clk_div   = 16'd16;
    rx_ready  = 1'b0;
    clear_err = 1'b0;
    tick(3);
    check("rst rx_data", rx_data, 0);
    check("rst rx_valid", rx_valid, 0);
    check("rst rx_busy", rx_busy, 0);
    check("rst frame_err", frame_err, 0);
    check("rst overrun", overrun, 0);
    check("rst level", fifo_level, 0);
    rst_n = 1'b1;
    tick(4);

    // Single byte; stop sample lands 3 + 8 + 9*16 = 155 clocks after the line drops.
    send_frame(8'h0A, 1'b1);
    check("0A latency", rise_cyc - start_cyc, 155);
    check("0A level", fifo_level, 1);
    check("0A frame_err", frame_err, 0);
    check("0A overrun", overrun, 0);
    pop_expect("0A pop", 8'h0A);
    check("0A empty", rx_valid, 0);

    // Slow divisor, two frames back to back with no consumer.
    clk_div = 16'd1042;
    tick(2);
    send_frame(8'h0F, 1'b1);
    send_frame(8'h3D, 1'b1);
    check("slow level", fifo_level, 2);
    pop_expect("slow pop0", 8'h0F);
    pop_expect("slow pop1", 8'h3D);
    check("slow empty", rx_valid, 0);

    // Five bytes into a four-deep FIFO: last one dropped.
    clk_div = 16'd16;
    tick(2);
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    check("ovr level", fifo_level, 4);
    check("ovr flag", overrun, 1);
    check("ovr frame_err", frame_err, 0);
    for (int i = 1; i <= 4; i++) pop_expect("ovr pop", 8'(i));
    check("ovr empty", rx_valid, 0);
    check("ovr sticky", overrun, 1);
    pulse_clear();
    check("ovr cleared", overrun, 0);

    // Stop bit low, line held low three bit times in total.
    send_frame(8'h55, 1'b0);
    bit_time(1'b0);
    bit_time(1'b0);
    check("brk frame_err", frame_err, 1);
    check("brk busy", rx_busy, 1);
    check("brk level", fifo_level, 0);
    bit_time(1'b1);
    check("brk idle", rx_busy, 0);
    send_frame(8'hA3, 1'b1);
    check("A3 level", fifo_level, 1);
    check("A3 sticky", frame_err, 1);
    pop_expect("A3 pop", 8'hA3);
    pulse_clear();
    check("fe cleared", frame_err, 0);

    // Five-clock low glitch: START holds for div/2 = 8 clocks, then back to IDLE.
    tick(4);
    busy_base = busy_total;
    rx = 1'b0;
    tick(5);
    rx = 1'b1;
    tick(20);
    check("glitch busy len", busy_total - busy_base, 8);
    check("glitch busy", rx_busy, 0);
    check("glitch valid", rx_valid, 0);
    check("glitch frame_err", frame_err, 0);
    check("glitch overrun", overrun, 0);

    // Async reset in the middle of a data bit with two bytes queued.
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    check("pre-rst level", fifo_level, 2);
    bit_time(1'b0);
    rx = 1'b1;
    tick(20);
    check("pre-rst busy", rx_busy, 1);
    #3 rst_n = 1'b0;
    #1;
    check("mid rst rx_data", rx_data, 0);
    check("mid rst rx_valid", rx_valid, 0);
    check("mid rst rx_busy", rx_busy, 0);
    check("mid rst level", fifo_level, 0);
    check("mid rst overrun", overrun, 0);
    tick(3);
    rst_n = 1'b1;
    tick(3);
    send_frame(8'h7E, 1'b1);
    check("7E level", fifo_level, 1);
    pop_expect("7E pop", 8'h7E);
    check("7E frame_err", frame_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
